// File: rtl/fmrv32im_uart_pkg.sv
// Shared UART definitions for the fmrv32im RX and TX blocks: FSM encoding,
// 8N1 frame constants and the oversample clock divider calculation.
package fmrv32im_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clock cycles per oversample tick, truncated toward zero.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/fmrv32im_uart_rx_if.sv
// Register-side handshake bundle of the UART receiver. The receiver drives
// the master side; the core-side consumer uses the slave side.
interface fmrv32im_uart_rx_if
  import fmrv32im_uart_pkg::*;
#(
  parameter int CNT_W = 5
);
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_READY;
  logic [CNT_W-1:0]     RX_COUNT;
  logic                 RX_FERR;
  logic                 RX_OVERRUN;
  logic                 ERR_CLR;

  modport master (
    output RX_DATA, RX_VALID, RX_COUNT, RX_FERR, RX_OVERRUN,
    input  RX_READY, ERR_CLR
  );

  modport slave (
    input  RX_DATA, RX_VALID, RX_COUNT, RX_FERR, RX_OVERRUN,
    output RX_READY, ERR_CLR
  );
endinterface

// File: rtl/fmrv32im_uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// `head` whenever the FIFO is not empty; a push into a full FIFO is only
// taken when a pop frees a slot in the same cycle.
module fmrv32im_uart_rx_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array; holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fmrv32im_uart_rx.sv
// UART 8N1 receiver front-end: pin synchroniser, oversample tick generator,
// frame FSM with shift register, sticky error flags and an output FIFO.
module fmrv32im_uart_rx
  import fmrv32im_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               UART_rx,
  fmrv32im_uart_rx_if.master rx_bus
);
  localparam int DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TICK_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  if (DIV < 2) begin : g_bad_div
    $error("fmrv32im_uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("fmrv32im_uart_rx: OVERSAMPLE must be even and at least 8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fmrv32im_uart_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic                 sync_1, rx_s, rx_q;
  logic [1:0]           warm;
  logic                 start_edge;
  rx_state_e            state, state_next;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick_clr, os_clr, os_inc, shift_en, push_set, ferr_set;
  logic                 push_q, ferr, overrun, overrun_set;
  logic                 fifo_full, fifo_empty, pop;
  logic [DATA_BITS-1:0] head;
  logic [CNT_W-1:0]     count;

  // The edge register only arms once the synchroniser holds a real pin
  // sample, so a line still low after reset never looks like a start edge.
  assign start_edge = rx_q & ~rx_s;
  assign tick       = (tick_cnt == TICK_W'(DIV - 1));

  // Two-flop synchroniser plus the previous-sample register for edge detect.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
      rx_q   <= 1'b0;
      warm   <= 2'b00;
    end else begin
      sync_1 <= UART_rx;
      rx_s   <= sync_1;
      warm   <= {warm[0], 1'b1};
      rx_q   <= rx_s & warm[1];
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle strobes; samples are taken on the last tick of
  // each bit period, and at half a bit for the start bit.
  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    os_clr     = 1'b0;
    os_inc     = 1'b0;
    shift_en   = 1'b0;
    push_set   = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
          tick_clr   = 1'b1;
          os_clr     = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt == OS_W'(OVERSAMPLE / 2 - 1)) begin
            os_clr     = 1'b1;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            os_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            os_clr   = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_next = STOP;
          end else begin
            os_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            os_clr = 1'b1;
            if (rx_s) begin
              push_set   = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_set   = 1'b1;
              state_next = BREAK;
            end
          end else begin
            os_inc = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Tick divider, oversample counter, bit counter and the registered push strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      push_q   <= 1'b0;
    end else begin
      if (tick_clr || tick) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + TICK_W'(1);
      if (os_clr)      os_cnt <= '0;
      else if (os_inc) os_cnt <= os_cnt + OS_W'(1);
      if (tick_clr)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BIT_W'(1);
      push_q <= push_set;
    end
  end

  // LSB-first shift register; it stays stable until the next frame's first
  // data bit, so the FIFO can take it directly on the push strobe.
  always_ff @(posedge CLK) begin
    if (shift_en) shift <= {rx_s, shift[DATA_BITS-1:1]};
  end

  assign pop         = ~fifo_empty & rx_bus.RX_READY;
  assign overrun_set = push_q & fifo_full & ~pop;

  // Sticky error flags; a new error wins over a clear in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (ferr_set)            ferr <= 1'b1;
      else if (rx_bus.ERR_CLR) ferr <= 1'b0;
      if (overrun_set)         overrun <= 1'b1;
      else if (rx_bus.ERR_CLR) overrun <= 1'b0;
    end
  end

  fmrv32im_uart_rx_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push_q),
    .push_data (shift),
    .pop       (rx_bus.RX_READY),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign rx_bus.RX_DATA    = head;
  assign rx_bus.RX_VALID   = ~fifo_empty;
  assign rx_bus.RX_COUNT   = count;
  assign rx_bus.RX_FERR    = ferr;
  assign rx_bus.RX_OVERRUN = overrun;
endmodule

// File: tb/tb_fmrv32im_uart_rx.sv
// Directed bench for fmrv32im_uart_rx. Instance A runs the default 115200 baud
// setup; instance B runs at a fast line rate (4 clocks per tick, 64 clocks
// per bit) so the multi-frame FIFO scenarios stay short.
module tb_fmrv32im_uart_rx;
  import fmrv32im_uart_pkg::*;

  localparam int BIT_A     = 868;      // 100 MHz / 115200, rounded
  localparam int FAST_BAUD = 1562500;  // 100 MHz / (16 * 4)
  localparam int DIV_B     = 4;
  localparam int BIT_B     = 64;
  // Clocks from the negedge that drops the pin to the FIFO write edge:
  // 3 to reach START, DIV-1 to the first tick, 151 more ticks to the stop
  // sample, one for the registered push strobe.
  localparam int PUSH_OFS_B = DIV_B * 152 + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a  = 1'b1;
  logic rx_b  = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fmrv32im_uart_rx_if #(.CNT_W(5)) bus_a ();
  fmrv32im_uart_rx_if #(.CNT_W(5)) bus_b ();

  fmrv32im_uart_rx dut_a (
    .CLK     (clk),
    .RST_N   (rst_n),
    .UART_rx (rx_a),
    .rx_bus  (bus_a)
  );

  fmrv32im_uart_rx #(.BAUD(FAST_BAUD)) dut_b (
    .CLK     (clk),
    .RST_N   (rst_n),
    .UART_rx (rx_b),
    .rx_bus  (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pin(input int idx, input logic v);
    if (idx == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic set_ready(input int idx, input logic v);
    if (idx == 0) bus_a.RX_READY = v;
    else          bus_b.RX_READY = v;
  endtask

  task automatic pulse_clr(input int idx);
    if (idx == 0) bus_a.ERR_CLR = 1'b1;
    else          bus_b.ERR_CLR = 1'b1;
    @(negedge clk);
    bus_a.ERR_CLR = 1'b0;
    bus_b.ERR_CLR = 1'b0;
  endtask

  task automatic pop_one(input int idx);
    set_ready(idx, 1'b1);
    @(negedge clk);
    set_ready(idx, 1'b0);
  endtask

  // Start bit, 8 data bits LSB first, then the given stop level.
  task automatic send_byte(input int idx, input logic [7:0] b, input logic stop, input int bitc);
    set_pin(idx, 1'b0);
    wait_cyc(bitc);
    for (int i = 0; i < 8; i++) begin
      set_pin(idx, b[i]);
      wait_cyc(bitc);
    end
    set_pin(idx, stop);
    wait_cyc(bitc);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.RX_READY = 1'b0;
    bus_a.ERR_CLR  = 1'b0;
    bus_b.RX_READY = 1'b0;
    bus_b.ERR_CLR  = 1'b0;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);

    // Reset values, line idle high
    check("a_rst_valid", 32'(bus_a.RX_VALID), 32'h0);
    check("a_rst_data",  32'(bus_a.RX_DATA), 32'h0);
    check("a_rst_count", 32'(bus_a.RX_COUNT), 32'h0);
    check("a_rst_ferr",  32'(bus_a.RX_FERR), 32'h0);
    check("a_rst_ovr",   32'(bus_a.RX_OVERRUN), 32'h0);
    check("a_rst_state", 32'(dut_a.state), 32'(IDLE));
    check("b_rst_valid", 32'(bus_b.RX_VALID), 32'h0);
    check("b_rst_count", 32'(bus_b.RX_COUNT), 32'h0);

    // Single byte at 115200
    send_byte(0, 8'hA5, 1'b1, BIT_A);
    check("a_byte_valid", 32'(bus_a.RX_VALID), 32'h1);
    check("a_byte_data",  32'(bus_a.RX_DATA), 32'hA5);
    check("a_byte_count", 32'(bus_a.RX_COUNT), 32'h1);
    check("a_byte_ferr",  32'(bus_a.RX_FERR), 32'h0);
    check("a_byte_ovr",   32'(bus_a.RX_OVERRUN), 32'h0);
    pop_one(0);
    check("a_pop_valid",  32'(bus_a.RX_VALID), 32'h0);
    check("a_pop_count",  32'(bus_a.RX_COUNT), 32'h0);

    // 3 us glitch is a false start
    set_pin(0, 1'b0);
    wait_cyc(300);
    set_pin(0, 1'b1);
    wait_cyc(1000);
    check("a_glitch_count", 32'(bus_a.RX_COUNT), 32'h0);
    check("a_glitch_ferr",  32'(bus_a.RX_FERR), 32'h0);
    check("a_glitch_ovr",   32'(bus_a.RX_OVERRUN), 32'h0);
    check("a_glitch_state", 32'(dut_a.state), 32'(IDLE));
    send_byte(0, 8'h3C, 1'b1, BIT_A);
    check("a_3c_valid", 32'(bus_a.RX_VALID), 32'h1);
    check("a_3c_data",  32'(bus_a.RX_DATA), 32'h3C);
    check("a_3c_count", 32'(bus_a.RX_COUNT), 32'h1);
    pop_one(0);
    check("a_3c_pop", 32'(bus_a.RX_VALID), 32'h0);

    // Framing error: stop bit low, line held low two more bits
    send_byte(0, 8'h55, 1'b0, BIT_A);
    wait_cyc(2 * BIT_A);
    set_pin(0, 1'b1);
    wait_cyc(20);
    check("a_ferr_flag",  32'(bus_a.RX_FERR), 32'h1);
    check("a_ferr_count", 32'(bus_a.RX_COUNT), 32'h0);
    check("a_ferr_ovr",   32'(bus_a.RX_OVERRUN), 32'h0);
    check("a_ferr_state", 32'(dut_a.state), 32'(IDLE));
    pulse_clr(0);
    check("a_ferr_clr", 32'(bus_a.RX_FERR), 32'h0);

    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(1, 8'(i), 1'b1, BIT_B);
    check("b_ovr_count", 32'(bus_b.RX_COUNT), 32'd16);
    check("b_ovr_flag",  32'(bus_b.RX_OVERRUN), 32'h1);
    check("b_ovr_ferr",  32'(bus_b.RX_FERR), 32'h0);
    for (int i = 0; i < 16; i++) begin
      check("b_ovr_drain", 32'(bus_b.RX_DATA), 32'(i));
      pop_one(1);
    end
    check("b_ovr_empty", 32'(bus_b.RX_VALID), 32'h0);
    check("b_ovr_count0", 32'(bus_b.RX_COUNT), 32'h0);
    pulse_clr(1);
    check("b_ovr_clr", 32'(bus_b.RX_OVERRUN), 32'h0);

    // Full boundary: pop lands in the exact push cycle of 0x7E
    for (int i = 0; i < 16; i++) send_byte(1, 8'(32'h60 + i), 1'b1, BIT_B);
    check("b_full_count", 32'(bus_b.RX_COUNT), 32'd16);
    fork
      send_byte(1, 8'h7E, 1'b1, BIT_B);
      begin
        wait_cyc(PUSH_OFS_B);
        set_ready(1, 1'b1);
        wait_cyc(1);
        set_ready(1, 1'b0);
      end
    join
    check("b_full_count2", 32'(bus_b.RX_COUNT), 32'd16);
    check("b_full_ovr",    32'(bus_b.RX_OVERRUN), 32'h0);
    for (int i = 1; i < 16; i++) begin
      check("b_full_drain", 32'(bus_b.RX_DATA), 32'(32'h60 + i));
      pop_one(1);
    end
    check("b_full_last", 32'(bus_b.RX_DATA), 32'h7E);
    pop_one(1);
    check("b_full_empty", 32'(bus_b.RX_VALID), 32'h0);

    // Reset mid-frame with the line still low after release
    send_byte(1, 8'h42, 1'b1, BIT_B);
    check("b_pre_rst_count", 32'(bus_b.RX_COUNT), 32'h1);
    set_pin(1, 1'b0);
    wait_cyc(200);
    rst_n = 1'b0;
    wait_cyc(3);
    check("b_in_rst_count", 32'(bus_b.RX_COUNT), 32'h0);
    check("b_in_rst_valid", 32'(bus_b.RX_VALID), 32'h0);
    rst_n = 1'b1;
    wait_cyc(1500);
    check("b_low_state", 32'(dut_b.state), 32'(IDLE));
    check("b_low_ferr",  32'(bus_b.RX_FERR), 32'h0);
    check("b_low_count", 32'(bus_b.RX_COUNT), 32'h0);
    set_pin(1, 1'b1);
    wait_cyc(10);
    send_byte(1, 8'h81, 1'b1, BIT_B);
    check("b_post_rst_data",  32'(bus_b.RX_DATA), 32'h81);
    check("b_post_rst_count", 32'(bus_b.RX_COUNT), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fmrv32im_uart_rx.md
# fmrv32im_uart_rx

UART receive front-end sitting between the board pin `uart_txd_in` and the fmrv32im SoC's UART peripheral register interface. It synchronises the asynchronous serial line, detects and validates start bits, and recovers 8N1 frames using 16× oversampling. Received bytes are buffered in a small FIFO and presented to the core on a valid/ready handshake, with sticky framing-error and overrun flags.

## Interface
- `CLK_FREQ`, 100000000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥ 8.
- `FIFO_DEPTH`, 16: bytes buffered; must be a power of two and ≥ 2.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST_N`  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- `UART_rx`  in  1  serial line, idle high, asynchronous to `CLK`.
- `RX_DATA`  out  8  byte at the FIFO head; reset 0x00.
- `RX_VALID`  out  1  FIFO not empty; reset 0.
- `RX_READY`  in  1  consumer accepts the head byte when `RX_VALID && RX_READY`.
- `RX_COUNT`  out  clog2(FIFO_DEPTH)+1  bytes currently held; reset 0.
- `RX_FERR`  out  1  sticky framing error; reset 0.
- `RX_OVERRUN`  out  1  sticky overrun; reset 0.
- `ERR_CLR`  in  1  one-cycle pulse that clears both sticky flags.

## Operation
- Line sync: 2-flop synchroniser with reset value 1. The FSM sees only the synchronised `rx_s`.
- Tick generator:
  - `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, truncated. Elaboration fails if `DIV < 2`. The default gives 54.
  - Counts 0..DIV-1 and emits `tick` on DIV-1.
  - Reset to 0 on every transition out of IDLE, so frame phase is aligned to the start edge.
- FSM states: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
- IDLE: when `rx_s` goes from 1 to 0 → START; the tick counter and sample counter clear.
- START: on tick `OVERSAMPLE/2-1` (mid-bit), sample `rx_s`.
  - 1 → IDLE. This is a false start; no flag is set.
  - 0 → DATA, with the sample counter cleared.
- DATA: every `OVERSAMPLE` ticks, sample `rx_s` into the shift register LSB first. After bit 7 → STOP.
- STOP: after `OVERSAMPLE` ticks, sample `rx_s`.
  - 1 → push the byte, then IDLE.
  - 0 → set `RX_FERR`, discard the byte, go to BREAK.
- BREAK: wait for `rx_s == 1`, then IDLE. No new frame is accepted while the line is low.
- FIFO: first-word-fall-through. `RX_DATA` is valid whenever `RX_VALID` is 1.
- Pop occurs when `RX_VALID && RX_READY`.
- Push while full:
  - If a pop occurs in the same cycle, the push is accepted and the count is unchanged.
  - Otherwise the byte is dropped and `RX_OVERRUN` is set.
- Pointers wrap modulo `FIFO_DEPTH`. The count distinguishes full from empty.
- Sticky flags: set has priority over `ERR_CLR` in the same cycle.
- Reset mid-frame: all state is cleared immediately and the FIFO empties. After release, a line that is still low does not start a frame until a new 1→0 edge.

## Timing
- Start-edge detection latency: 3 `CLK` cycles from the pin edge (2 sync flops + edge register).
- Frame acceptance: a byte is pushed in the cycle after the stop-bit sample. `RX_VALID` rises one `CLK` after the push, and `RX_COUNT` updates in the same cycle.
- Pop: `RX_DATA` shows the next entry, and `RX_VALID`/`RX_COUNT` update, one cycle after the handshake.
- Simultaneous push and pop on an empty FIFO: the push is accepted; `RX_VALID` = 1 next cycle.
- Baud tolerance: mid-bit sampling tolerates ±4% total clock mismatch over 10 bits.

## Structure
- Shared package `fmrv32im_uart_pkg`:
  - FSM state encoding.
  - `DIV` computation function.
  - 8N1 frame constants (data bits 8, stop bits 1).
  - This package is reused by the TX block.
- Sub-module `fmrv32im_uart_rx_fifo`: parameterised FWFT synchronous FIFO with push, pop, full, empty and count.
- Top-level holds: synchroniser, tick generator, FSM, shift register, sticky flags.

## Test plan
- Reset behaviour: hold `RST_N`=0, then release with line high → all outputs at reset values and FSM in IDLE.
- Single byte: 0xA5 at 115200 baud with `RX_READY`=0 → `RX_VALID`=1, `RX_DATA`=0xA5, `RX_COUNT`=1, both flags 0. Then pulse `RX_READY` → `RX_VALID`=0 next cycle.
- False start:
  - 3 µs low glitch (< half bit) → no push and no flags.
  - A following 0x3C frame → received correctly.
- Framing error:
  - 0x55 with stop bit forced 0, then line held low for 2 bit times, then high → `RX_FERR`=1, `RX_COUNT`=0.
  - `ERR_CLR` pulse → `RX_FERR`=0.
- Overrun:
  - 17 back-to-back frames 0x00..0x10 with `RX_READY`=0 → `RX_COUNT`=16, `RX_OVERRUN`=1.
  - Draining yields 0x00..0x0F in order.
- Full boundary: FIFO full, with `RX_READY`=1 asserted in the exact push cycle of frame 0x7E → no overrun, `RX_COUNT` stays 16, 0x7E is last out.
